// File: rtl/laser_timer_pkg.sv
// Shared types and constants for the laser trigger pulse timer.
// The counter-width helper is evaluated at elaboration time only.
package laser_timer_pkg;

  typedef enum logic {
    OFF = 1'b0,
    ON  = 1'b1
  } state_t;

  localparam int unsigned DEFAULT_PULSE_CYCLES = 3;

  function automatic int cnt_width(input int unsigned n);
    int w;
    w = $clog2(n + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/laser_timer_if.sv
// Button-in / laser-enable-out pair. The controller side is the slave:
// it samples B and drives X.
interface laser_timer_if;
  logic B;
  logic X;

  modport master (output B, input X);
  modport slave  (input B, output X);
endinterface

// File: rtl/laser_timer.sv
// Single-shot laser enable timer: one sampled press gives exactly
// PULSE_CYCLES cycles of X high. Presses during a pulse are ignored.
//
//   state | meaning
//   ------+-------------------------------------------------------
//   OFF   | idle, X=0, waiting for B=1 at a rising edge
//   ON    | pulse active, X=1, cnt counts down the remaining cycles
module laser_timer
  import laser_timer_pkg::*;
#(
  parameter int unsigned PULSE_CYCLES = DEFAULT_PULSE_CYCLES
) (
  input  logic          Clk,
  input  logic          Rst,
  laser_timer_if.slave  bus
);

  localparam int             CW   = cnt_width(PULSE_CYCLES);
  localparam logic [CW-1:0]  LOAD = CW'(PULSE_CYCLES - 1);

  state_t          state;
  logic [CW-1:0]   cnt;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state <= OFF;
      cnt   <= '0;
    end else if (state == ON) begin
      // cnt beyond LOAD can only come from a corrupted flop; drop the pulse.
      if (cnt == '0 || cnt > LOAD) begin
        state <= OFF;
        cnt   <= '0;
      end else begin
        cnt   <= cnt - CW'(1);
      end
    end else begin
      if (bus.B) begin
        state <= ON;
        cnt   <= LOAD;
      end else begin
        state <= OFF;
        cnt   <= '0;
      end
    end
  end

  // Decoded from the state flop alone, so X never follows B combinationally.
  assign bus.X = (state == ON);

endmodule

// File: tb/tb_laser_timer.sv
// Bench for laser_timer: directed vector table on the default-width
// instance, hand-written corner sequences, and a randomized run of three
// instances (PULSE_CYCLES = 3, 1, 5) against a remaining-cycles model.
module tb_laser_timer;

  logic Clk;
  logic Rst;

  laser_timer_if if3 ();
  laser_timer_if if1 ();
  laser_timer_if if5 ();

  laser_timer #(.PULSE_CYCLES(3)) dut3 (.Clk(Clk), .Rst(Rst), .bus(if3.slave));
  laser_timer #(.PULSE_CYCLES(1)) dut1 (.Clk(Clk), .Rst(Rst), .bus(if1.slave));
  laser_timer #(.PULSE_CYCLES(5)) dut5 (.Clk(Clk), .Rst(Rst), .bus(if5.slave));

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    logic rst;
    logic b;
    logic exp_x;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input int act, input int exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance one rising edge and land 2ns after it, away from the edge.
  task automatic step();
    @(posedge Clk);
    #2;
  endtask

  task automatic add(input logic r, input logic b, input logic x);
    vec_t v;
    v.rst = r; v.b = b; v.exp_x = x;
    vecs.push_back(v);
  endtask

  // Count how many consecutive edges X stays high after a single trigger.
  task automatic sweep(input int which, input int exp_len);
    int len;
    len = 0;
    if (which == 1) if1.B = 1'b1; else if5.B = 1'b1;
    step();
    if (which == 1) if1.B = 1'b0; else if5.B = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (((which == 1) ? if1.X : if5.X) !== 1'b1) break;
      len++;
      step();
    end
    chk((which == 1) ? "sweep_P1_len" : "sweep_P5_len", len, exp_len);
    chk((which == 1) ? "sweep_P1_idle" : "sweep_P5_idle",
        int'((which == 1) ? if1.X : if5.X), 0);
  endtask

  initial begin
    int rem[3];
    int pc[3];
    logic [2:0] bv;
    logic [2:0] xv;

    pc[0] = 3; pc[1] = 1; pc[2] = 5;
    Rst = 1'b1;
    if3.B = 1'b0; if1.B = 1'b0; if5.B = 1'b0;

    // reset, basic pulse, retrigger ignored, held button and drain
    add(1, 0, 0);
    add(0, 1, 1); add(0, 0, 1); add(0, 0, 1); add(0, 0, 0);
    add(0, 1, 1); add(0, 1, 1); add(0, 1, 1); add(0, 0, 0);
    add(0, 1, 1); add(0, 1, 1); add(0, 1, 1); add(0, 1, 0); add(0, 1, 1);
    add(0, 1, 1); add(0, 1, 1); add(0, 1, 0); add(0, 1, 1); add(0, 1, 1);
    add(0, 0, 1); add(0, 0, 0); add(0, 0, 0);

    #2;
    for (int i = 0; i < vecs.size(); i++) begin
      Rst   = vecs[i].rst;
      if3.B = vecs[i].b;
      step();
      chk($sformatf("vec%0d_X", i), int'(if3.X), int'(vecs[i].exp_x));
    end
    if3.B = 1'b0;

    // async reset in the middle of a pulse, no clock edge involved
    if3.B = 1'b1;
    step();
    if3.B = 1'b0;
    step();
    chk("midpulse_before_rst", int'(if3.X), 1);
    #1 Rst = 1'b1;
    #1 chk("midpulse_async_rst", int'(if3.X), 0);
    Rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("no_resume_after_rst", int'(if3.X), 0);
    end

    // async reset while idle takes effect without an edge too
    #1 Rst = 1'b1;
    #1 chk("idle_async_rst", int'(if3.X), 0);
    Rst = 1'b0;
    step();

    // B pulse that never overlaps a rising edge
    #1 if3.B = 1'b1;
    #1 if3.B = 1'b0;
    step();
    chk("narrow_b_ignored", int'(if3.X), 0);
    step();
    chk("narrow_b_ignored2", int'(if3.X), 0);

    // a fresh trigger after all that still produces a full pulse
    if3.B = 1'b1;
    step();
    if3.B = 1'b0;
    chk("retrigger_after_rst", int'(if3.X), 1);
    step(); step(); step();
    chk("retrigger_after_rst_end", int'(if3.X), 0);

    sweep(1, 1);
    sweep(5, 5);

    // randomized run of all three instances against the reference
    rem[0] = 0; rem[1] = 0; rem[2] = 0;
    for (int n = 0; n < 400; n++) begin
      bv = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) bv = 3'b111;
      if3.B = bv[0]; if1.B = bv[1]; if5.B = bv[2];
      @(posedge Clk);
      for (int i = 0; i < 3; i++) begin
        if (rem[i] > 0) rem[i] = rem[i] - 1;
        else if (bv[i]) rem[i] = pc[i];
      end
      #2;
      xv = {if5.X, if1.X, if3.X};
      for (int i = 0; i < 3; i++)
        chk($sformatf("rand%0d_P%0d_X", n, pc[i]), int'(xv[i]), (rem[i] > 0) ? 1 : 0);
      if ($urandom_range(0, 24) == 0) begin
        #1 Rst = 1'b1;
        #1 chk($sformatf("rand%0d_rst_X", n), int'({if5.X, if1.X, if3.X}), 0);
        Rst = 1'b0;
        rem[0] = 0; rem[1] = 0; rem[2] = 0;
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
